// File: rtl/shift_arb.sv
// shift_arb: two-requester round-robin arbiter that feeds a single-entry
// result register with a signed-amount barrel shift of the winning operand.
//
// Configuration macro: SHIFT_ARB_ARITH_EN
//   defined   -> right shifts fill with A[WIDTH-1] (arithmetic)
//   undefined -> right shifts fill with 0 (logical)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   req0_valid  requester 0 operation pending
//   req0_ready  requester 0 accepted this cycle (with req0_valid)
//   req0_a      requester 0 operand [WIDTH]
//   req0_b      requester 0 signed shift amount [SHW]
//   req1_*      same as req0_* for requester 1
//   out_valid   result register holds a valid result
//   out_ready   consumer takes the result
//   out_y       shift result [WIDTH]
//   out_id      requester that owns out_y
//   done_cnt    completed output handshakes, wraps at 256
module shift_arb #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [SHW-1:0]   req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [SHW-1:0]   req1_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_id,
  output logic [7:0]       done_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic [WIDTH-1:0] r_y;
  logic             r_id;
  logic [7:0]       r_done;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc;
  logic [WIDTH-1:0] w_sel_a;
  logic [SHW-1:0]   w_sel_b;

  // Signed shift: non-negative B shifts left (zero fill), negative B shifts
  // right by |B|. The magnitude is one bit wider than B so the most negative
  // amount still negates correctly.
  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] a,
                                               input logic [SHW-1:0]   b);
    logic [SHW:0]     mag;
    logic             fill;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] res;
`ifdef SHIFT_ARB_ARITH_EN
    fill = a[WIDTH-1];
`else
    fill = 1'b0;
`endif
    if (b[SHW-1]) mag = (~{1'b1, b}) + (SHW+1)'(1);
    else          mag = {1'b0, b};
    mask = '1;
    if (b[SHW-1]) begin
      if (int'(mag) >= WIDTH) begin
        res = {WIDTH{fill}};
      end else begin
        mask = mask >> mag;
        res  = (a >> mag) | (~mask & {WIDTH{fill}});
      end
    end else begin
      if (int'(mag) >= WIDTH) res = '0;
      else                    res = a << mag;
    end
    return res;
  endfunction

  // Grants are only offered in IDLE and are held off while reset is asserted,
  // so a request coinciding with reset is never accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n) begin
          w_gnt0 = req0_valid & (~req1_valid | ~r_ptr);
          w_gnt1 = req1_valid & (~req0_valid |  r_ptr);
          if (w_gnt0 | w_gnt1) w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_acc   = w_gnt0 | w_gnt1;
  assign w_sel_a = w_gnt1 ? req1_a : req0_a;
  assign w_sel_b = w_gnt1 ? req1_b : req0_b;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr  <= 1'b0;
      r_y    <= '0;
      r_id   <= 1'b0;
      r_done <= '0;
    end else begin
      if (w_acc) begin
        r_y   <= f_shift(w_sel_a, w_sel_b);
        r_id  <= w_gnt1;
        r_ptr <= ~w_gnt1;
      end
      if (r_state == HOLD && out_ready) r_done <= r_done + 8'd1;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign out_valid  = (r_state == HOLD);
  assign out_y      = r_y;
  assign out_id     = r_id;
  assign done_cnt   = r_done;

endmodule

// File: doc/shift_arb.md
SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 Parameter WIDTH, default 8, data width of operand A and result Y.
REQ-002 Parameter SHW, default 3, width of the signed shift amount B (two's complement).
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-007 req0_a  input  WIDTH  requester 0 operand.
REQ-008 req0_b  input  SHW  requester 0 signed shift amount.
REQ-009 req1_valid, req1_ready, req1_a, req1_b SHALL mirror REQ-005..REQ-008 for requester 1.
REQ-010 out_valid  output  1  result register holds a valid result.
REQ-011 out_ready  input  1  consumer takes the result when high with out_valid.
REQ-012 out_y  output  WIDTH  shift result.
REQ-013 out_id  output  1  index of the requester that owns out_y.
REQ-014 done_cnt  output  8  count of completed output handshakes.

Function
REQ-015 Shift rule: B>=0 gives Y = A << B; B<0 gives Y = A >> (-B); result truncated to WIDTH; magnitude >= WIDTH gives all-fill result.
REQ-016 Left shifts SHALL zero-fill; right-shift fill is set by REQ-032/REQ-033.
REQ-017 FSM states: IDLE, HOLD; reset state IDLE.
REQ-018 IDLE: if any reqN_valid, exactly one reqN_ready SHALL be high (the arbitration winner), combinationally; both low otherwise.
REQ-019 Arbitration: round-robin with 1-bit priority pointer; if only one requester is valid it wins; if both are valid the pointer's requester wins.
REQ-020 On accept (reqN_valid & reqN_ready) the pointer SHALL move to the other requester, out_y/out_id SHALL be registered, and the FSM SHALL enter HOLD; out_valid high the next cycle (latency 1).
REQ-021 HOLD: both reqN_ready SHALL be low; out_y, out_id, out_valid SHALL remain stable while out_ready is low.
REQ-022 HOLD with out_ready high: FSM returns to IDLE, out_valid low next cycle, done_cnt increments; no accept in that same cycle (max throughput one result per 2 cycles).
REQ-023 done_cnt SHALL wrap from 255 to 0.
REQ-024 A requester deasserting valid before acceptance SHALL not be granted; the pointer SHALL change only on accept.
REQ-025 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-026 Reset SHALL be sampled only on rising clk edges with rst_n low.
REQ-027 During/after reset: FSM IDLE, pointer 0, out_valid 0, out_y 0, out_id 0, done_cnt 0, req0_ready/req1_ready 0 while rst_n low.
REQ-028 Reset in HOLD SHALL discard the pending result without incrementing done_cnt.
REQ-029 Reset in the same cycle as a request SHALL take priority; the request is not accepted.

Configuration
REQ-030 Exactly one macro: SHIFT_ARB_ARITH_EN.
REQ-031 The macro SHALL affect only the right-shift fill value.
REQ-032 Defined: right shifts fill with A[WIDTH-1] (arithmetic).
REQ-033 Undefined: right shifts fill with 0 (logical).

Verification (WIDTH=8, SHW=3)
REQ-034 req0 A=8'h0F B=3'b010 -> accepted, next cycle out_valid=1, out_y=8'h3C, out_id=0.
REQ-035 req1 A=8'h80 B=3'b111 -> out_y=8'h40 without macro, 8'hC0 with macro; B=3'b100 -> 8'h08 / 8'hF8.
REQ-036 Both valid continuously from reset, out_ready=1 -> grants 0,1,0,1 on alternate cycles; out_id follows.
REQ-037 out_ready held low 5 cycles in HOLD -> out_y stable, req0_ready=req1_ready=0, done_cnt unchanged.
REQ-038 rst_n low one cycle in HOLD -> out_valid=0, done_cnt=0, next grant to requester 0 when both are valid.
REQ-039 256 completed handshakes -> done_cnt=0; 257th -> 1.
